// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- 8-bit asynchronous serial transmitter (8N1, optionally 8E1/8O1).
//
// A byte is accepted from a valid/ready source while the transmitter idles,
// then sent as: one start bit (0), eight data bits LSB first, an optional
// parity bit and one stop bit (1). Every bit lasts CLKS_PER_BIT clocks.
//
// Build option:
//   UART_TX_PARITY_EN  -- when defined, a parity bit is inserted between the
//                         last data bit and the stop bit. PARITY_ODD selects
//                         even (0) or odd (1) parity. When undefined, no
//                         parity state or parity logic is built.
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  // Parameter legality is checked while the design is elaborated.
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx: CLKS_PER_BIT must be 2..65535 and PARITY_ODD 0 or 1");
  end

  localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_cnt_d;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_d;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_d;
  logic             tx_q;
  logic             tx_d;
  logic             handshake;
  logic             bit_end;

  assign handshake = (state == IDLE) && tx_valid;
  assign bit_end   = (baud_cnt == CNT_LAST);

  // State register: the only place the FSM state changes.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic: advance one frame field per completed bit time.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (handshake) state_d = START;
      START: if (bit_end)   state_d = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_end && bit_idx == 3'd7) state_d = PARITY;
      PARITY: if (bit_end)                    state_d = STOP;
`else
      DATA:   if (bit_end && bit_idx == 3'd7) state_d = STOP;
`endif
      STOP:  if (bit_end)   state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Datapath next values: baud timing, bit index and the rotating data register.
  always_comb begin
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift_reg;

    // The baud counter runs in every busy state and clears on each bit boundary.
    if (state == IDLE || bit_end) begin
      baud_cnt_d = '0;
    end else begin
      baud_cnt_d = baud_cnt + CNT_W'(1);
    end

    if (handshake) begin
      shift_d = tx_data;
    end

    if (state == START) begin
      bit_idx_d = 3'd0;
    end else if (state == DATA && bit_end) begin
      // Rotating (rather than shifting out) restores the original byte after
      // eight bits, so the parity bit can still be computed from it.
      bit_idx_d = bit_idx + 3'd1;
      shift_d   = {shift_reg[0], shift_reg[7:1]};
    end
  end

  // Serial line value for the cycle after this edge, derived from next state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = (^shift_d) ^ 1'(PARITY_ODD);
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // Datapath registers, including the registered serial line.
  // NOTE: the data register is reset along with the control state so that a
  // reset leaves no stale byte behind; it is a plain flop bank, not a memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      baud_cnt  <= baud_cnt_d;
      bit_idx   <= bit_idx_d;
      shift_reg <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // Output decode: handshake and status flags follow the current state only.
  always_comb begin
    tx_ready = (state == IDLE);
    busy     = (state != IDLE);
    done     = (state == STOP) && bit_end;
    tx       = tx_q;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 2..65535.
- REQ-002: Parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity; used only when UART_TX_PARITY_EN is defined.
- REQ-003: clk  input  1  clock; all state changes on the rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous, active-low.
- REQ-005: tx_valid  input  1  byte offer from the upstream source.
- REQ-006: tx_data  input  8  byte to send; sampled only on handshake.
- REQ-007: tx_ready  output  1  high only while in IDLE; a byte is accepted when tx_valid and tx_ready are both high on a rising edge.
- REQ-008: tx  output  1  serial line; idle level is 1.
- REQ-009: busy  output  1  high in every state except IDLE.
- REQ-010: done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
- REQ-011: The state machine SHALL have states IDLE, START, DATA, PARITY (present only with UART_TX_PARITY_EN) and STOP.
- REQ-012: IDLE->START on handshake; tx_data is latched into an 8-bit shift register on the same edge.
- REQ-013: tx SHALL be registered: 0 in START, the current data bit in DATA, the parity bit in PARITY, 1 in STOP and IDLE.
- REQ-014: Each of START, each DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter of width clog2(CLKS_PER_BIT); the counter clears at each bit boundary.
- REQ-015: Data SHALL be sent LSB first; a 3-bit index counts 0..7, and START->DATA loads index 0.
- REQ-016: DATA->PARITY (or ->STOP when parity is compiled out) SHALL occur after index 7 completes; the index wraps to 0 and never exceeds 7.
- REQ-017: STOP->IDLE occurs on the edge ending the stop bit; done is high during the final stop-bit cycle.
- REQ-018: Frame length SHALL be 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity; the first tx=0 cycle follows the handshake edge.
- REQ-019: Back-to-back operation: with tx_valid held high, the next handshake occurs on the first IDLE cycle, giving exactly one idle-high cycle between frames.
- REQ-020: tx_data and tx_valid changes while tx_ready is low SHALL be ignored and SHALL not corrupt the frame in flight.
- REQ-021: tx_ready SHALL be combinationally (state==IDLE) and SHALL not depend on tx_valid.

Reset
- REQ-022: While rst_n is low: state=IDLE, tx=1, tx_ready=1, busy=0, done=0, and the baud counter, bit index and shift register are all 0.
- REQ-023: Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), driving tx to 1; no partial frame resumes after release.
- REQ-024: The first handshake SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
- REQ-025: Macro UART_TX_PARITY_EN defined: the PARITY state is inserted after DATA, with tx = ^data XOR PARITY_ODD for one bit time.
- REQ-026: Macro UART_TX_PARITY_EN undefined: no PARITY state or parity logic exists, and DATA goes directly to STOP.

Verification
- REQ-027: CLKS_PER_BIT=4, no parity, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); done pulses once in cycle 40.
- REQ-028: UART_TX_PARITY_EN with PARITY_ODD=0, send 0xA5 -> parity bit 0 and frame of 44 cycles; with PARITY_ODD=1, send 0x01 -> parity bit 0; with PARITY_ODD=0, send 0x01 -> parity bit 1.
- REQ-029: tx_valid held high with 0x00 then 0xFF -> two frames separated by exactly one tx=1 idle cycle; tx_ready high only during that cycle.
- REQ-030: Drive tx_data to 0x3C mid-frame while sending 0x55 -> the serialized bits still match 0x55.
- REQ-031: Assert rst_n low during DATA bit 3 -> tx=1, busy=0, tx_ready=1 immediately; after release, send 0x81 -> a clean full frame.
- REQ-032: CLKS_PER_BIT=2 (minimum), send 0xFF -> every bit lasts 2 cycles and the frame lasts 20 cycles.
